// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Decoupled instruction-fetch front end. Holds the fetch PC and issues one
// word request at a time to instruction memory over a req/ack handshake.
// Returned words are buffered with their PC in a DEPTH-entry FIFO whose head
// feeds the IF/ID latch. A flush redirects the fetch PC and drops everything
// queued or in flight.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   flush_i     redirect to brTarget_i, discard queue and in-flight data
//   brTarget_i  redirect PC (bits [1:0] ignored)
//   stall_i     consumer not ready, head is held
//   memReq_o    instruction-memory request valid
//   memAddr_o   request byte address, stable while memReq_o=1
//   memAck_i    memory accepts request, memData_i valid same cycle
//   memData_i   returned instruction word
//   valid_o     head entry valid
//   inst_o      head instruction (NOP when empty)
//   PCInst_o    head PC (0 when empty)
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] brTarget_i,
  input  logic        stall_i,
  output logic        memReq_o,
  output logic [31:0] memAddr_o,
  input  logic        memAck_i,
  input  logic [31:0] memData_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] PCInst_o
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam logic [AW+1:0]  DEPTH_L = (AW+2)'(DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [DEPTH];
  entry_t        head;

  logic          pop, push, issue;
  logic [AW+1:0] level_idle, level_wait;
  logic [1:0]    br_align_unused;

  // Low target bits are architecturally zero for word-aligned fetch.
  assign br_align_unused = brTarget_i[1:0];

  assign valid_o = (count != '0);
  assign pop     = valid_o & ~stall_i & ~flush_i;
  assign push    = (state == S_WAIT) & memAck_i & ~flush_i;

  // Occupancy once this cycle's pop (and, in WAIT, the push) has landed.
  // A new request is only issued while this leaves a free slot, which is
  // what guarantees the FIFO can never be overfilled.
  assign level_idle = {1'b0, count} - (AW+2)'(pop);
  assign level_wait = level_idle + (AW+2)'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!flush_i && (level_idle < DEPTH_L)) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          // Without an ack the address must stay on the bus until the
          // memory takes it; the returning word is then thrown away.
          state_next = memAck_i ? S_IDLE : S_DISCARD;
        end else if (memAck_i) begin
          if (level_wait < DEPTH_L) begin
            issue      = 1'b1;
            state_next = S_WAIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (memAck_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_next;

      if (flush_i) begin
        fetch_pc <= {brTarget_i[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (issue) req_addr <= fetch_pc;

      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, because valid_o is derived from count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{pc: req_addr, inst: memData_i};
  end

  assign head      = mem[rd_ptr];
  assign memReq_o  = (state != S_IDLE);
  assign memAddr_o = req_addr;
  assign inst_o    = valid_o ? head.inst : NOP;
  assign PCInst_o  = valid_o ? head.pc   : 32'h0000_0000;

endmodule
